// File: rtl/srcnn_tile_addr_gen.sv
// srcnn_tile_addr_gen: walks an n_rows x n_cols tile and streams row*stride+col buffer addresses
// using an external zero-latency multiplier, under ap_start/ap_done block control.
module srcnn_tile_addr_gen #(
    parameter int ROW_W  = 5,
    parameter int COL_W  = 6,
    parameter int ADDR_W = 9
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ROW_W-1:0]  n_rows,
    input  logic [COL_W-1:0]  n_cols,
    input  logic [COL_W-1:0]  row_stride,
    output logic [ROW_W-1:0]  mul_din0,
    output logic [COL_W-1:0]  mul_din1,
    input  logic [ADDR_W-1:0] mul_dout,
    output logic [ADDR_W-1:0] addr_TDATA,
    output logic              addr_TVALID,
    input  logic              addr_TREADY,
    output logic              addr_TLAST
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, rows_q, rows_d;
    logic [COL_W-1:0] col_q, col_d, cols_q, cols_d, stride_q, stride_d;
    logic [ADDR_W-1:0] tdata_q, tdata_d;
    logic go_q, go_d, tvalid_q, tvalid_d, tlast_q, tlast_d, load, col_end;
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        stride_d = stride_q;
        go_d     = go_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        load     = 1'b0;
        col_end  = col_q == cols_q - COL_W'(1);
        case (state_q)
            IDLE: if (ap_start) begin
                rows_d   = n_rows;
                cols_d   = n_cols;
                stride_d = row_stride;
                row_d    = '0;
                col_d    = '0;
                go_d     = 1'b0;
                state_d  = (n_rows == '0 || n_cols == '0) ? DONE : RUN;
            end
            RUN: begin
                // go_q spends one cycle letting the latched operands settle through the multiplier
                go_d = 1'b1;
                load = go_q && !tlast_q && (!tvalid_q || addr_TREADY);
                if (tvalid_q && addr_TREADY && tlast_q) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = DONE;
                end
                if (load) begin
                    tdata_d  = mul_dout + ADDR_W'(col_q);
                    tvalid_d = 1'b1;
                    tlast_d  = row_q == rows_q - ROW_W'(1) && col_end;
                    col_d    = col_end ? '0 : col_q + COL_W'(1);
                    row_d    = col_end ? row_q + ROW_W'(1) : row_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            stride_q <= '0;
            go_q     <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            stride_q <= stride_d;
            go_q     <= go_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end
    assign ap_idle     = state_q == IDLE;
    assign ap_done     = state_q == DONE;
    assign ap_ready    = state_q == DONE;
    assign mul_din0    = row_q;
    assign mul_din1    = stride_q;
    assign addr_TDATA  = tdata_q;
    assign addr_TVALID = tvalid_q;
    assign addr_TLAST  = tlast_q;
endmodule

// File: tb/tb_srcnn_tile_addr_gen.sv
// tb_srcnn_tile_addr_gen: directed tiles with hand-computed address sequences, stalls, resets and restarts.
module tb_srcnn_tile_addr_gen;
    logic       ap_clk = 0, ap_rst = 1, ap_start = 0;
    logic       ap_done, ap_idle, ap_ready;
    logic [4:0] n_rows = 0, mul_din0;
    logic [5:0] n_cols = 0, row_stride = 0, mul_din1;
    logic [8:0] mul_dout, addr_TDATA;
    logic       addr_TVALID, addr_TREADY = 1, addr_TLAST;
    logic [8:0] exp_addr [16];
    int         total = 0, passed = 0, fails = 0;

    always #5 ap_clk = ~ap_clk;

    // 5x6 -> 9 unsigned multiplier, product truncated to 9 bits
    assign mul_dout = 9'(mul_din0) * 9'(mul_din1);

    srcnn_tile_addr_gen dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .n_rows(n_rows), .n_cols(n_cols),
        .row_stride(row_stride), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .addr_TDATA(addr_TDATA), .addr_TVALID(addr_TVALID), .addr_TREADY(addr_TREADY),
        .addr_TLAST(addr_TLAST)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        assert (got === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
        end
    endtask

    task automatic start(input int r, input int c, input int s);
        @(negedge ap_clk);
        n_rows = 5'(r); n_cols = 6'(c); row_stride = 6'(s); ap_start = 1;
    endtask

    // First iteration observes the edge that sampled ap_start; stops on the idle cycle after ap_done.
    task automatic collect(input int nexp, input bit stall, input bit hold);
        int got = 0, cyc = 0, dones = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
        logic [8:0] pd = 0;
        logic pl = 0;
        bit stalled = 0;
        while (cyc < 200) begin
            @(negedge ap_clk);
            cyc++;
            ap_start = hold;
            if (hold && cyc == 4) begin n_cols = 6'd1; row_stride = 6'd33; end
            if (stalled) begin
                chk("stall_data", addr_TDATA, pd);
                chk("stall_last", addr_TLAST, pl);
            end
            if (ap_done) begin
                dones++;
                done_cyc = cyc;
                chk("ready_with_done", ap_ready, 1);
            end
            if (ap_idle && dones > 0) break;
            addr_TREADY = stall ? (cyc % 3 == 1) : 1'b1;
            stalled = 0;
            if (addr_TVALID) begin
                if (first_cyc == 0) first_cyc = cyc;
                if (addr_TREADY) begin
                    chk("beat_data", addr_TDATA, got < 16 ? exp_addr[got] : 9'h1ff);
                    chk("beat_last", addr_TLAST, got == nexp - 1);
                    got++;
                    last_cyc = cyc;
                end else begin
                    stalled = 1;
                    pd = addr_TDATA;
                    pl = addr_TLAST;
                end
            end
        end
        chk("beat_count", got, nexp);
        chk("done_count", dones, 1);
        chk("done_cycle", done_cyc, nexp == 0 ? 1 : last_cyc + 1);
        if (nexp > 0) chk("latency", first_cyc, 3);
    endtask

    initial begin
        repeat (2) @(negedge ap_clk);
        chk("rst_idle", ap_idle, 1);
        chk("rst_valid", addr_TVALID, 0);
        chk("rst_data", addr_TDATA, 0);
        chk("rst_last", addr_TLAST, 0);
        chk("rst_done", ap_done, 0);
        chk("rst_din0", mul_din0, 0);
        chk("rst_din1", mul_din1, 0);
        ap_rst = 0;

        exp_addr[0:5] = '{9'd0, 9'd1, 9'd2, 9'd10, 9'd11, 9'd12};
        start(2, 3, 10);
        collect(6, 0, 0);
        start(2, 3, 10);
        collect(6, 1, 0);

        start(0, 3, 10);
        collect(0, 0, 0);
        start(2, 0, 10);
        collect(0, 0, 0);

        exp_addr[0:9] = '{9'd0, 9'd63, 9'd126, 9'd189, 9'd252, 9'd315, 9'd378, 9'd441, 9'd504, 9'd55};
        start(10, 1, 63);
        collect(10, 0, 0);

        start(2, 3, 10);
        repeat (5) @(negedge ap_clk) ap_start = 0;
        chk("pre_rst_data", addr_TDATA, 2);
        chk("pre_rst_valid", addr_TVALID, 1);
        ap_rst = 1;
        @(negedge ap_clk);
        ap_rst = 0;
        chk("abort_valid", addr_TVALID, 0);
        chk("abort_idle", ap_idle, 1);
        chk("abort_din0", mul_din0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            chk("abort_no_done", ap_done, 0);
            chk("abort_no_valid", addr_TVALID, 0);
        end
        exp_addr[0:5] = '{9'd0, 9'd1, 9'd2, 9'd10, 9'd11, 9'd12};
        start(2, 3, 10);
        collect(6, 0, 0);

        start(2, 3, 10);
        collect(6, 0, 1);
        n_rows = 5'd1; n_cols = 6'd2; row_stride = 6'd5;
        exp_addr[0:1] = '{9'd0, 9'd1};
        collect(2, 0, 0);
        chk("final_idle", ap_idle, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
